// File: rtl/xs3_pkg.sv
// xs3_pkg: shared constants and FSM state type for the excess-3 decoder.
//   XS3_OFFSET : excess-3 bias subtracted from each code
//   XS3_MIN/MAX: legal excess-3 code range (digits 0..9)
//   state_t    : decoder FSM states
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/xs3_digit_decode.sv
// xs3_digit_decode: combinational single-digit excess-3 to BCD decode.
//   in_code [3:0] : excess-3 code
//   bcd     [3:0] : decoded 8421 digit
//   illegal       : code outside 0011..1100
// Optional feature macro: XS3_DEC_ERR_EN
//   defined   -> illegal codes flagged and forced to 0000
//   undefined -> no detection, every code decodes as (c - 3) mod 16
module xs3_digit_decode
  import xs3_pkg::*;
(
  input  logic [3:0] in_code,
  output logic [3:0] bcd,
  output logic       illegal
);

`ifdef XS3_DEC_ERR_EN
  always_comb begin
    illegal = (in_code < XS3_MIN) || (in_code > XS3_MAX);
    bcd     = illegal ? 4'b0000 : (in_code - XS3_OFFSET);
  end
`else
  always_comb begin
    illegal = 1'b0;
    bcd     = in_code - XS3_OFFSET;
  end
`endif

endmodule

// File: rtl/xs3_to_bcd_decoder.sv
// xs3_to_bcd_decoder: collects excess-3 digits (MSD first) into a packed,
// right-justified BCD word presented on a valid/ready output port.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input digit handshake
//   in_code [3:0]       : excess-3 digit
//   in_last             : final digit of the current word
//   out_valid/out_ready : output word handshake
//   out_bcd [4*DIGITS-1:0], out_err, out_count [CW-1:0] : registered word
// Optional feature macro: XS3_DEC_ERR_EN (see xs3_digit_decode).
module xs3_to_bcd_decoder
  import xs3_pkg::*;
#(
  parameter  int unsigned DIGITS = 4,
  localparam int unsigned CW     = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_code,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic [CW-1:0]         out_count
);

  state_t state, state_nxt;

  logic [4*DIGITS-1:0] shift_reg;
  logic [4*DIGITS-1:0] dig_ext;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_inc;
  logic                err;
  logic [3:0]          dig_bcd;
  logic                dig_ill;
  logic                accept;
  logic                word_done;
  logic                out_fire;

  xs3_digit_decode u_digit_decode (
    .in_code (in_code),
    .bcd     (dig_bcd),
    .illegal (dig_ill)
  );

  // Zero-extend the new digit so the shift works for DIGITS == 1 as well.
  always_comb begin
    dig_ext      = '0;
    dig_ext[3:0] = dig_bcd;
  end

  assign accept    = (state == COLLECT) && in_valid;
  assign out_fire  = (state == HOLD) && out_ready;
  assign cnt_inc   = cnt + 1'b1;
  assign word_done = accept && (in_last || (cnt_inc == CW'(DIGITS)));

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (word_done) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || out_fire) begin
      shift_reg <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      shift_reg <= (shift_reg << 4) | dig_ext;
      cnt       <= cnt_inc;
      err       <= err | dig_ill;
    end
  end

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign out_bcd   = shift_reg;
  assign out_err   = err;
  assign out_count = cnt;

endmodule
